// File: rtl/alu_ccr_unit.sv
// alu_ccr_unit: registered execute-stage ALU with an N/C/Z condition-code register
// and a bit-serial shifter. Define ALU_FLAG_SHADOW_EN to build the CCR shadow register.

package alu_ccr_pkg;

   typedef enum logic [3:0] {
      OP_NOP  = 4'b0000,
      OP_NOT  = 4'b0001,
      OP_ADD  = 4'b0010,
      OP_PASS = 4'b0011,
      OP_SUB  = 4'b0100,
      OP_AND  = 4'b0101,
      OP_OR   = 4'b0110,
      OP_INC  = 4'b0111,
      OP_DEC  = 4'b1000,
      OP_SETC = 4'b1001,
      OP_CLRC = 4'b1010,
      OP_SHL  = 4'b1011,
      OP_SHR  = 4'b1100
   } opcode_t;

   typedef struct packed {
      logic n;
      logic c;
      logic z;
   } ccr_t;

   // Flag-update masks share the CCR layout: a set bit means that flag is written.
   localparam ccr_t MASK_NONE = 3'b000;
   localparam ccr_t MASK_NZ   = 3'b101;
   localparam ccr_t MASK_C    = 3'b010;
   localparam ccr_t MASK_NCZ  = 3'b111;

   typedef enum logic {
      ST_IDLE,
      ST_SHIFT
   } state_t;

endpackage

module alu_ccr_unit
   import alu_ccr_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   output logic [WIDTH-1:0] out,
   output logic             out_valid,
   output logic [2:0]       flags,
   input  logic             flag_save,
   input  logic             flag_restore
);

   state_t           state;
   ccr_t             ccr;
   logic [WIDTH-1:0] work;
   logic [SHW-1:0]   cnt;
   logic             shl_dir;

   logic             accept;
   logic [SHW-1:0]   k;

   assign accept   = in_valid && in_ready;
   assign k        = in2[SHW-1:0];
   assign in_ready = (state == ST_IDLE);
   assign flags    = ccr;

   // ------------------------------------------------------------------
   // Single-cycle datapath: result is computed WIDTH+1 wide so the top bit
   // carries the carry/borrow for the arithmetic opcodes.
   // ------------------------------------------------------------------
   logic [WIDTH:0] alu_ext;
   logic           alu_res_en;
   ccr_t           alu_mask;
   logic           alu_c;
   logic           shift_start;

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no opcode arm can leave one unassigned and infer a latch.
      alu_ext     = {1'b0, in1};
      alu_res_en  = 1'b0;
      alu_mask    = MASK_NONE;
      alu_c       = 1'b0;
      shift_start = 1'b0;
      case (op)
         OP_NOT: begin
            alu_ext    = {1'b0, ~in2};
            alu_res_en = 1'b1;
            alu_mask   = MASK_NZ;
         end
         OP_ADD: begin
            alu_ext    = {1'b0, in1} + {1'b0, in2};
            alu_res_en = 1'b1;
            alu_mask   = MASK_NCZ;
            alu_c      = alu_ext[WIDTH];
         end
         OP_PASS: begin
            alu_res_en = 1'b1;
         end
         OP_SUB: begin
            alu_ext    = {1'b0, in1} - {1'b0, in2};
            alu_res_en = 1'b1;
            alu_mask   = MASK_NCZ;
            alu_c      = alu_ext[WIDTH];
         end
         OP_AND: begin
            alu_ext    = {1'b0, in1 & in2};
            alu_res_en = 1'b1;
            alu_mask   = MASK_NZ;
         end
         OP_OR: begin
            alu_ext    = {1'b0, in1 | in2};
            alu_res_en = 1'b1;
            alu_mask   = MASK_NZ;
         end
         OP_INC: begin
            alu_ext    = {1'b0, in2} + {{WIDTH{1'b0}}, 1'b1};
            alu_res_en = 1'b1;
            alu_mask   = MASK_NCZ;
            alu_c      = alu_ext[WIDTH];
         end
         OP_DEC: begin
            alu_ext    = {1'b0, in2} - {{WIDTH{1'b0}}, 1'b1};
            alu_res_en = 1'b1;
            alu_mask   = MASK_NCZ;
            alu_c      = alu_ext[WIDTH];
         end
         OP_SETC: begin
            alu_mask = MASK_C;
            alu_c    = 1'b1;
         end
         OP_CLRC: begin
            alu_mask = MASK_C;
            alu_c    = 1'b0;
         end
         OP_SHL, OP_SHR: begin
            // A zero-distance shift passes in1 through in one cycle and keeps C.
            if (k == '0) begin
               alu_res_en = 1'b1;
               alu_mask   = MASK_NZ;
            end else begin
               shift_start = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // ------------------------------------------------------------------
   // One-bit shift step and the completion mux shared by both paths.
   // ------------------------------------------------------------------
   logic [WIDTH-1:0] work_next;
   logic             shout_bit;

   always_comb begin
      if (shl_dir) begin
         work_next = {work[WIDTH-2:0], 1'b0};
         shout_bit = work[WIDTH-1];
      end else begin
         work_next = {1'b0, work[WIDTH-1:1]};
         shout_bit = work[0];
      end
   end

   logic             shift_last;
   logic             comp_en;
   logic             comp_res_en;
   ccr_t             comp_mask;
   logic             comp_c;
   logic [WIDTH-1:0] comp_res;

   assign shift_last = (state == ST_SHIFT) && (cnt == SHW'(1));

   always_comb begin
      comp_en     = 1'b0;
      comp_res_en = 1'b0;
      comp_mask   = MASK_NONE;
      comp_c      = 1'b0;
      comp_res    = alu_ext[WIDTH-1:0];
      if (shift_last) begin
         comp_en     = 1'b1;
         comp_res_en = 1'b1;
         comp_mask   = MASK_NCZ;
         comp_c      = shout_bit;
         comp_res    = work_next;
      end else if (state == ST_IDLE && accept) begin
         comp_en     = 1'b1;
         comp_res_en = alu_res_en;
         comp_mask   = alu_mask;
         comp_c      = alu_c;
      end
   end

   // ------------------------------------------------------------------
   // CCR next value: restore (if built) lands first, the op update overlays it.
   // ------------------------------------------------------------------
   ccr_t ccr_base;
   ccr_t ccr_next;

`ifdef ALU_FLAG_SHADOW_EN
   ccr_t shadow;

   assign ccr_base = flag_restore ? shadow : ccr;

   // Save captures the CCR as it was before this edge; a concurrent restore wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         shadow <= MASK_NONE;
      else if (flag_save && !flag_restore)
         shadow <= ccr;
   end
`else
   logic unused_shadow_ports;

   assign unused_shadow_ports = flag_save | flag_restore;
   assign ccr_base            = ccr;
`endif

   always_comb begin
      ccr_next = ccr_base;
      if (comp_en) begin
         if (comp_mask.n) ccr_next.n = comp_res[WIDTH-1];
         if (comp_mask.c) ccr_next.c = comp_c;
         if (comp_mask.z) ccr_next.z = (comp_res == '0);
      end
   end

   // ------------------------------------------------------------------
   // Control FSM with registered result, strobe and CCR.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         out       <= '0;
         out_valid <= 1'b0;
         ccr       <= MASK_NONE;
         work      <= '0;
         cnt       <= '0;
         shl_dir   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make every register sample pre-edge values regardless of statement order.
         out_valid <= 1'b0;
         ccr       <= ccr_next;
         if (comp_en && comp_res_en) begin
            out       <= comp_res;
            out_valid <= 1'b1;
         end
         case (state)
            ST_IDLE: begin
               if (accept && shift_start) begin
                  work    <= in1;
                  cnt     <= k;
                  shl_dir <= (op == OP_SHL);
                  state   <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               work <= work_next;
               cnt  <= cnt - SHW'(1);
               if (shift_last)
                  state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/alu_ccr_unit.md
# alu_ccr_unit

Parametrised, registered ALU with a condition-code register (CCR) for the pipelined processor's execute stage. It generalises the combinational ALU in four ways: configurable data width, a larger opcode set, registered N/C/Z flags with per-opcode update masks, and a multi-cycle barrel-free shifter sequenced by a state machine. It accepts one operation per handshake and presents a registered result with a one-cycle `out_valid` strobe. Flags persist across operations until updated, restored or reset.

## Interface
- `WIDTH`, 16, data width of operands and result (≥4).
- `SHW`, `$clog2(WIDTH)`, width of the shift-amount field taken from `in2[SHW-1:0]`.
- `clk`  in  1  system clock, all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  operation present on `op`/`in1`/`in2`.
- `in_ready`  out  1  unit can accept; handshake fires when `in_valid && in_ready`.
- `op`  in  4  opcode.
- `in1`, `in2`  in  WIDTH  operands.
- `out`  out  WIDTH  registered result, held between results.
- `out_valid`  out  1  one-cycle strobe, `out` is new this cycle.
- `flags`  out  3  CCR `{N, C, Z}` (bit 2 = Negative, bit 1 = Carry, bit 0 = Zero).
- `flag_save`  in  1  copy CCR to shadow register.
- `flag_restore`  in  1  load CCR from shadow register.

## Operation
- Opcodes (result; flags updated):
  - `0000` NOP: no result; no flags.
  - `0001` NOT `~in2`: N, Z.
  - `0010` ADD `in1+in2`: N, C = carry out, Z.
  - `0011` PASS `in1` (LDM/LDD/STD): no flags.
  - `0100` SUB `in1-in2`: N, C = borrow (`in1<in2` unsigned), Z.
  - `0101` AND: N, Z.
  - `0110` OR: N, Z.
  - `0111` INC `in2+1`: N, C, Z.
  - `1000` DEC `in2-1`: N, C = borrow (`in2==0`), Z.
  - `1001` SETC: C=1; no result.
  - `1010` CLRC: C=0; no result.
  - `1011` SHL `in1 << k`: N, C = last bit shifted out, Z.
  - `1100` SHR `in1 >> k` (logical): N, C = last bit shifted out, Z.
  - `1101`–`1111` are treated as NOP.
- `k = in2[SHW-1:0]`. When `k=0`, the result is `in1`, C is held, and N and Z are updated.
- N = `out[WIDTH-1]`. Z = (`out == 0`). All arithmetic is WIDTH-bit with the carry/borrow at bit WIDTH.
- State machine: IDLE and SHIFT.
  - In IDLE, `in_ready=1`.
  - Accepting SHL/SHR with `k≥1` loads the working register with `in1` and the counter with `k`, then moves to SHIFT.
  - In SHIFT, `in_ready=0`. Each cycle shifts one bit, captures the bit shifted out and decrements the counter.
  - When the counter reaches 0, SHIFT writes `out`, asserts `out_valid`, updates the CCR and returns to IDLE.
- Every other accepted op (and a shift with `k=0`) completes from IDLE in one cycle.
- Flag priority on any edge: `flag_restore` first, then the completing op's flag update. `flag_save` samples the CCR value before this edge's update.
- Simultaneous `flag_save` and `flag_restore`: restore takes effect; the shadow register is unchanged.
- `in_valid` low, or a NOP/reserved opcode: no state change and no `out_valid`.

## Timing
- Reset values: `out=0`, `out_valid=0`, `flags=000`, shadow `=000`, state IDLE, `in_ready=1`.
- Single-cycle op accepted at edge T: `out`/`flags` update at T+1, with `out_valid=1` for the cycle after T+1.
- Shift with `k≥1` accepted at T: `in_ready=0` from T+1 until completion, with result at edge T+k.
- Back-to-back single-cycle ops are sustained at one per cycle.
- SETC/CLRC: the CCR updates at T+1, and `out_valid` stays 0.
- `rst` asserted mid-shift aborts immediately. No `out_valid` is produced for the aborted shift, and all registers take their reset values.

## Configuration
- `ALU_FLAG_SHADOW_EN`
  - Defined: the shadow register and the save/restore behaviour above are compiled in.
  - Undefined: no shadow register exists, and `flag_save`/`flag_restore` are ignored. The ports remain on the interface.

## Test plan
- Reset, then ADD `0xFFFF+0x0001` → `out=0x0000`, `flags=011`, `out_valid` one cycle after accept.
- SUB `0x0003-0x0005` → `out=0xFFFE`, `flags=110`. Then PASS `0x0000` → `out=0x0000`, flags stay `110`.
- SHL `in1=0x8001`, `in2=3`: `in_ready` low 3 cycles → `out=0x0008`, C=0, `flags=000`. Then SHR `in1=0x0003`, `in2=2` → `out=0x0000`, `flags=011`.
- SETC, then NOT `in2=0x00FF` → `out=0xFF00`, `flags=110`. Then SHL with `k=0` on `in1=0x0000` → `flags=011` after one cycle.
- With `ALU_FLAG_SHADOW_EN`:
  - Set `flags=110`, pulse `flag_save`, then run ADD `0+0` → `flags=001`.
  - Then pulse `flag_restore` in the same cycle an ADD `0xFFFF+1` is accepted → `flags=011` (the op's update follows the restore).
  - Rebuild without the macro → the restore has no effect.
- Assert `rst` during the 2nd cycle of a 10-bit shift → `out=0`, `flags=000`, `in_ready=1`, no `out_valid`. The next ADD `2+2` then completes normally → `out=0x0004`.
